// File: rtl/axis_pixel_unpacker.sv
// axis_pixel_unpacker: unpacks 32-bit AXI-Stream words (four 8-bit pixels,
// LSB first) into one DATA_WIDTH sample per clock, enforcing FRAME_LEN
// pixels per frame. Short frames are zero padded; framing errors are sticky.
module axis_pixel_unpacker #(
  parameter int DATA_WIDTH = 16,
  parameter int FRAME_LEN  = 784,
  parameter int PIX_SHIFT  = 0
) (
  input  logic                  s_axi_aclk,
  input  logic                  s_axi_aresetn,
  input  logic [31:0]           s_axis_tdata,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  input  logic                  s_axis_tlast,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic                  m_last,
  input  logic                  flush,
  input  logic                  err_clr,
  output logic                  err_short,
  output logic                  err_long,
  output logic                  frame_done,
  output logic [15:0]           frame_cnt
);

  localparam int WORDS  = FRAME_LEN / 4;
  localparam int PIX_W  = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
  localparam int WCNT_W = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [PIX_W-1:0]  PIX_LAST  = PIX_W'(FRAME_LEN - 1);
  localparam logic [WCNT_W-1:0] WCNT_LAST = WCNT_W'(WORDS - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    UNPACK = 2'd1,
    PAD    = 2'd2
  } state_t;

  state_t state, state_nx;

  logic [31:0]           hold;
  logic                  hold_last;
  logic [1:0]            lane;
  logic [PIX_W-1:0]      pix;
  logic [WCNT_W-1:0]     wcnt;

  logic                  out_load;
  logic                  emit;
  logic                  lane3;
  logic                  pix_last;
  logic                  go_pad;
  logic                  word_acc;
  logic                  short_evt;
  logic                  long_evt;
  logic [7:0]            lane_byte;
  logic [DATA_WIDTH-1:0] sample;

  // Select the current lane byte and scale it to the output width.
  always_comb begin
    lane_byte = hold[7:0];
    case (lane)
      2'd0:    lane_byte = hold[7:0];
      2'd1:    lane_byte = hold[15:8];
      2'd2:    lane_byte = hold[23:16];
      default: lane_byte = hold[31:24];
    endcase
    sample = DATA_WIDTH'(lane_byte) << PIX_SHIFT;
  end

  // Handshake decode and next-state logic.
  // A tlast word that ends early must not let a new word in while the
  // lane-3 sample moves the FSM into PAD, so tready is held off there.
  always_comb begin
    state_nx      = state;
    out_load      = ~m_valid | m_ready;
    emit          = out_load & (state != IDLE);
    lane3         = (lane == 2'd3);
    pix_last      = (pix == PIX_LAST);
    go_pad        = (state == UNPACK) & lane3 & hold_last & ~pix_last;
    s_axis_tready = (state == IDLE) |
                    ((state == UNPACK) & lane3 & out_load & ~go_pad);
    word_acc      = s_axis_tvalid & s_axis_tready;
    short_evt     = emit & go_pad;
    long_evt      = word_acc & ~s_axis_tlast & (wcnt == WCNT_LAST);
    case (state)
      IDLE: begin
        if (word_acc) state_nx = UNPACK;
      end
      UNPACK: begin
        if (emit && lane3) begin
          if (go_pad)        state_nx = PAD;
          else if (word_acc) state_nx = UNPACK;
          else               state_nx = IDLE;
        end
      end
      PAD: begin
        if (emit && pix_last) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn)  state <= IDLE;
    else if (flush)      state <= IDLE;
    else                 state <= state_nx;
  end

  // Holding register, lane pointer and frame position counters.
  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      hold      <= '0;
      hold_last <= 1'b0;
      lane      <= '0;
      pix       <= '0;
      wcnt      <= '0;
    end else if (flush) begin
      hold      <= '0;
      hold_last <= 1'b0;
      lane      <= '0;
      pix       <= '0;
      wcnt      <= '0;
    end else begin
      if (word_acc) begin
        hold      <= s_axis_tdata;
        hold_last <= s_axis_tlast;
        lane      <= '0;
        if (s_axis_tlast || (wcnt == WCNT_LAST)) wcnt <= '0;
        else                                     wcnt <= wcnt + 1'b1;
      end else if (emit && (state == UNPACK)) begin
        lane <= lane + 2'd1;
      end
      if (emit) begin
        if (pix_last) pix <= '0;
        else          pix <= pix + 1'b1;
      end
    end
  end

  // Registered output stage; holds its sample while stalled.
  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      m_data  <= '0;
      m_valid <= 1'b0;
      m_last  <= 1'b0;
    end else if (flush) begin
      m_data  <= '0;
      m_valid <= 1'b0;
      m_last  <= 1'b0;
    end else if (out_load) begin
      m_valid <= (state != IDLE);
      m_last  <= (state != IDLE) & pix_last;
      if (state == UNPACK)   m_data <= sample;
      else if (state == PAD) m_data <= '0;
    end
  end

  // Sticky error flags, frame completion pulse and frame counter.
  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      err_short  <= 1'b0;
      err_long   <= 1'b0;
      frame_done <= 1'b0;
      frame_cnt  <= '0;
    end else if (flush) begin
      err_short  <= 1'b0;
      err_long   <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      err_short  <= (err_short & ~err_clr) | short_evt;
      err_long   <= (err_long & ~err_clr) | long_evt;
      frame_done <= m_valid & m_ready & m_last;
      if (m_valid && m_ready && m_last) frame_cnt <= frame_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_axis_pixel_unpacker.sv
// Scoreboard bench for axis_pixel_unpacker: the stimulus side pushes the
// expected sample stream into a queue, a monitor pops on every output
// handshake.
module tb_axis_pixel_unpacker;

  localparam int FL    = 784;
  localparam int WORDS = FL / 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] tdata = '0;
  logic        tvalid = 1'b0;
  logic        tlast = 1'b0;
  logic        tready;
  logic [15:0] m_data;
  logic        m_valid;
  logic        m_ready = 1'b1;
  logic        m_last;
  logic        flush = 1'b0;
  logic        err_clr = 1'b0;
  logic        err_short;
  logic        err_long;
  logic        frame_done;
  logic [15:0] frame_cnt;

  logic [31:0] sc_tdata = '0;
  logic        sc_tvalid = 1'b0;
  logic        sc_tlast = 1'b0;
  logic        sc_tready;
  logic [15:0] sc_m_data;
  logic        sc_m_valid;
  logic        sc_m_last;
  logic        sc_err_short;
  logic        sc_err_long;
  logic        sc_frame_done;
  logic [15:0] sc_frame_cnt;

  always #5 clk = ~clk;

  axis_pixel_unpacker dut (
    .s_axi_aclk    (clk),
    .s_axi_aresetn (rst_n),
    .s_axis_tdata  (tdata),
    .s_axis_tvalid (tvalid),
    .s_axis_tready (tready),
    .s_axis_tlast  (tlast),
    .m_data        (m_data),
    .m_valid       (m_valid),
    .m_ready       (m_ready),
    .m_last        (m_last),
    .flush         (flush),
    .err_clr       (err_clr),
    .err_short     (err_short),
    .err_long      (err_long),
    .frame_done    (frame_done),
    .frame_cnt     (frame_cnt)
  );

  axis_pixel_unpacker #(
    .DATA_WIDTH (16),
    .FRAME_LEN  (4),
    .PIX_SHIFT  (8)
  ) dut_sc (
    .s_axi_aclk    (clk),
    .s_axi_aresetn (rst_n),
    .s_axis_tdata  (sc_tdata),
    .s_axis_tvalid (sc_tvalid),
    .s_axis_tready (sc_tready),
    .s_axis_tlast  (sc_tlast),
    .m_data        (sc_m_data),
    .m_valid       (sc_m_valid),
    .m_ready       (1'b1),
    .m_last        (sc_m_last),
    .flush         (1'b0),
    .err_clr       (1'b0),
    .err_short     (sc_err_short),
    .err_long      (sc_err_long),
    .frame_done    (sc_frame_done),
    .frame_cnt     (sc_frame_cnt)
  );

  typedef struct packed {
    logic [15:0] d;
    logic        l;
  } smp_t;

  smp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;
  int   mpix = 0;
  int   mw = 0;
  bit   exp_short = 1'b0;
  bit   exp_long = 1'b0;
  int   exp_cnt = 0;
  bit   rnd_ready = 1'b0;
  int   cyc = 0;
  int   first_cyc = 0;
  int   last_cyc = 0;
  bit   want_first = 1'b0;
  bit   stall_prev = 1'b0;
  bit   pend_done = 1'b0;
  logic [15:0] stall_d = '0;
  logic        stall_l = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Reference: pixels are the word bytes in order, numbered modulo FL;
  // an early tlast fills the rest of the frame with zeros.
  function automatic void model_word(input logic [31:0] d, input bit last);
    logic [7:0] b;
    for (int i = 0; i < 4; i++) begin
      b = d[8*i +: 8];
      exp_q.push_back('{d: 16'(b), l: (mpix == FL - 1)});
      mpix = (mpix + 1) % FL;
    end
    if (last) begin
      if (mpix != 0) begin
        exp_short = 1'b1;
        while (mpix != 0) begin
          exp_q.push_back('{d: 16'h0, l: (mpix == FL - 1)});
          mpix = (mpix + 1) % FL;
        end
      end
      mw = 0;
    end else begin
      if (mw == WORDS - 1) exp_long = 1'b1;
      mw = (mw + 1) % WORDS;
    end
  endfunction

  task automatic send_word(input logic [31:0] d, input bit last);
    bit acc;
    int n;
    tdata  = d;
    tlast  = last;
    tvalid = 1'b1;
    model_word(d, last);
    acc = 1'b0;
    n   = 0;
    while (!acc && n < 4000) begin
      @(negedge clk);
      acc = tready;
      @(posedge clk);
      #1;
      n++;
    end
    if (!acc) begin
      checks++;
      errors++;
      $display("FAIL send_word: word 0x%0h not accepted within %0d cycles", d, n);
    end
    tvalid = 1'b0;
    tlast  = 1'b0;
  endtask

  task automatic send_frame(input int nw, input int last_at, input bit rnd);
    logic [31:0] d;
    for (int k = 0; k < nw; k++) begin
      if (rnd) d = $urandom;
      else     d = {8'(4*k+3), 8'(4*k+2), 8'(4*k+1), 8'(4*k)};
      send_word(d, (k + 1) == last_at);
    end
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || m_valid) && n < 20000) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= 20000) begin
      checks++;
      errors++;
      $display("FAIL %s drain: %0d samples still expected, m_valid=%0b", name, exp_q.size(), m_valid);
    end
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic clear_err();
    err_clr = 1'b1;
    @(posedge clk);
    #1;
    err_clr = 1'b0;
    exp_short = 1'b0;
    exp_long  = 1'b0;
  endtask

  task automatic chk_reset_values(input string tag);
    chk({tag, "_tready"},     32'(tready), 32'd1);
    chk({tag, "_m_valid"},    32'(m_valid), 32'd0);
    chk({tag, "_m_data"},     32'(m_data), 32'd0);
    chk({tag, "_m_last"},     32'(m_last), 32'd0);
    chk({tag, "_frame_done"}, 32'(frame_done), 32'd0);
    chk({tag, "_err_short"},  32'(err_short), 32'd0);
    chk({tag, "_err_long"},   32'(err_long), 32'd0);
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #1;
      m_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  initial begin
    smp_t e;
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst_n || flush) begin
        stall_prev = 1'b0;
        pend_done  = 1'b0;
      end else begin
        chk("frame_done", 32'(frame_done), 32'(pend_done));
        if (pend_done) chk("frame_cnt_at_done", 32'(frame_cnt), 32'(exp_cnt));
        pend_done = 1'b0;
        if (stall_prev) begin
          chk("stall_valid", 32'(m_valid), 32'd1);
          chk("stall_data",  32'(m_data), 32'(stall_d));
          chk("stall_last",  32'(m_last), 32'(stall_l));
        end
        if (m_valid && m_ready) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_sample: got data 0x%0h last %0b, expected none", m_data, m_last);
          end else begin
            e = exp_q.pop_front();
            chk("sample_data", 32'(m_data), 32'(e.d));
            chk("sample_last", 32'(m_last), 32'(e.l));
            if (e.l) begin
              exp_cnt   = (exp_cnt + 1) % 65536;
              pend_done = 1'b1;
            end
            if (want_first) begin
              first_cyc  = cyc;
              want_first = 1'b0;
            end
            last_cyc = cyc;
          end
        end
        stall_prev = m_valid && !m_ready;
        stall_d    = m_data;
        stall_l    = m_last;
      end
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1);
  end

  initial begin
    int n;
    repeat (3) @(posedge clk);
    #1;
    chk_reset_values("reset");
    chk("reset_frame_cnt", 32'(frame_cnt), 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Full frame, incrementing pixels, no backpressure.
    want_first = 1'b1;
    send_frame(WORDS, WORDS, 1'b0);
    wait_drain("full");
    chk("full_no_bubbles", 32'(last_cyc - first_cyc), 32'(FL - 1));
    chk("full_err_short", 32'(err_short), 32'(exp_short));
    chk("full_err_long",  32'(err_long), 32'(exp_long));
    chk("full_frame_cnt", 32'(frame_cnt), 32'd1);

    // Random data with random backpressure.
    rnd_ready = 1'b1;
    send_frame(WORDS, WORDS, 1'b1);
    wait_drain("backpressure");
    chk("bp_err_short", 32'(err_short), 32'(exp_short));
    chk("bp_err_long",  32'(err_long), 32'(exp_long));
    chk("bp_frame_cnt", 32'(frame_cnt), 32'd2);

    // Short frame: tlast on word 10.
    send_frame(10, 10, 1'b1);
    wait_drain("short");
    chk("short_err_short", 32'(err_short), 32'(exp_short));
    chk("short_err_long",  32'(err_long), 32'(exp_long));
    chk("short_frame_cnt", 32'(frame_cnt), 32'd3);
    clear_err();
    chk("short_err_clr", 32'(err_short), 32'd0);

    // Long frame: no tlast on the last word, err_clr coinciding with it.
    send_frame(WORDS - 1, 0, 1'b1);
    chk("long_err_before", 32'(err_long), 32'd0);
    err_clr = 1'b1;
    send_word($urandom, 1'b0);
    err_clr = 1'b0;
    chk("long_err_vs_clr", 32'(err_long), 32'(exp_long));
    send_frame(WORDS, WORDS, 1'b1);
    wait_drain("long");
    chk("long_err_long",  32'(err_long), 32'(exp_long));
    chk("long_err_short", 32'(err_short), 32'(exp_short));
    chk("long_frame_cnt", 32'(frame_cnt), 32'd5);
    clear_err();
    chk("long_err_clr", 32'(err_long), 32'd0);

    // Flush mid-frame keeps frame_cnt.
    send_frame(30, 0, 1'b1);
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    exp_q.delete();
    mpix = 0;
    mw   = 0;
    chk("flush_m_valid",   32'(m_valid), 32'd0);
    chk("flush_m_last",    32'(m_last), 32'd0);
    chk("flush_tready",    32'(tready), 32'd1);
    chk("flush_frame_cnt", 32'(frame_cnt), 32'd5);
    send_frame(WORDS, WORDS, 1'b1);
    wait_drain("after_flush");
    chk("after_flush_frame_cnt", 32'(frame_cnt), 32'd6);
    chk("after_flush_err_short", 32'(err_short), 32'd0);

    // Asynchronous reset mid-frame at word 50.
    send_frame(50, 0, 1'b1);
    #1;
    rst_n = 1'b0;
    #1;
    chk_reset_values("midreset");
    chk("midreset_frame_cnt", 32'(frame_cnt), 32'd0);
    exp_q.delete();
    mpix      = 0;
    mw        = 0;
    exp_cnt   = 0;
    rnd_ready = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    send_frame(WORDS, WORDS, 1'b0);
    wait_drain("after_reset");
    chk("after_reset_frame_cnt", 32'(frame_cnt), 32'd1);
    chk("after_reset_err_short", 32'(err_short), 32'd0);
    chk("after_reset_err_long",  32'(err_long), 32'd0);

    // Scaling instance: PIX_SHIFT=8, 4-pixel frames.
    chk("sc_tready", 32'(sc_tready), 32'd1);
    sc_tdata  = 32'h0000_80FF;
    sc_tlast  = 1'b1;
    sc_tvalid = 1'b1;
    @(posedge clk);
    #1;
    sc_tvalid = 1'b0;
    sc_tlast  = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!sc_m_valid && n < 10);
    chk("sc_valid",  32'(sc_m_valid), 32'd1);
    chk("sc_byte_ff", 32'(sc_m_data), 32'hFF00);
    @(negedge clk);
    chk("sc_byte_80", 32'(sc_m_data), 32'h8000);
    @(negedge clk);
    chk("sc_byte_2",  32'(sc_m_data), 32'h0000);
    @(negedge clk);
    chk("sc_last",    32'(sc_m_last), 32'd1);
    @(negedge clk);
    chk("sc_frame_done", 32'(sc_frame_done), 32'd1);
    chk("sc_frame_cnt",  32'(sc_frame_cnt), 32'd1);
    chk("sc_err_short",  32'(sc_err_short), 32'd0);
    chk("sc_err_long",   32'(sc_err_long), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
